// File: rtl/pipe_ctrl_if.sv
// Stall/flush and multiply/divide scheduler signal bundle for pipe_ctrl.
// master: pipeline side driving requests; slave: pipe_ctrl.
interface pipe_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             hz_stall;
    logic             br_taken;
    logic             ex_md_start;
    logic [1:0]       ex_md_op;
    logic             id_md_use;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] md_cnt;
    logic             md_err;
    logic [31:0]      perf_stall;
    logic [31:0]      perf_flush;

    modport master (
        output hz_stall, br_taken, ex_md_start, ex_md_op, id_md_use,
        input  pc_we, ifid_we, ifid_flush, idex_flush,
        input  md_busy, md_done, md_cnt, md_err,
        input  perf_stall, perf_flush
    );

    modport slave (
        input  hz_stall, br_taken, ex_md_start, ex_md_op, id_md_use,
        output pc_we, ifid_we, ifid_flush, idex_flush,
        output md_busy, md_done, md_cnt, md_err,
        output perf_stall, perf_flush
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer with multi-cycle HI/LO mult/div scheduler.
// Optional stall/flush performance counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave io
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             err_q;
    logic             md_busy;
    logic             md_stall;
    logic             stall;
    logic             sel_rst;
    logic             sel_stall;
    logic             sel_br;
    logic             sel_run;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             md_op_unused;

    // signedness (op[0]) only matters to the datapath
    assign md_op_unused = io.ex_md_op[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= io.ex_md_start & (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (io.ex_md_start) begin
                        if (io.ex_md_op[1]) begin
                            state_q <= S_DIV;
                            cnt_q   <= CNT_W'(DIV_CYCLES - 1);
                        end else begin
                            state_q <= S_MUL;
                            cnt_q   <= CNT_W'(MUL_CYCLES - 1);
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // DONE still stalls MD users: HI/LO is written at the end of that cycle
    assign md_busy  = (state_q != S_IDLE);
    assign md_stall = md_busy & io.id_md_use;
    assign stall    = io.hz_stall | md_stall;

    assign sel_rst   = ~rst_n;
    assign sel_stall = rst_n & stall;
    assign sel_br    = rst_n & ~stall & io.br_taken;
    assign sel_run   = rst_n & ~stall & ~io.br_taken;

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        unique case (1'b1)
            sel_rst: begin
            end
            sel_stall: begin
                idex_flush = 1'b1;
            end
            sel_br: begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
            end
            sel_run: begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
            end
        endcase
    end

    assign io.pc_we      = pc_we;
    assign io.ifid_we    = ifid_we;
    assign io.ifid_flush = ifid_flush;
    assign io.idex_flush = idex_flush;
    assign io.md_busy    = md_busy;
    assign io.md_done    = done_q;
    assign io.md_cnt     = cnt_q;
    assign io.md_err     = err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (ifid_flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign io.perf_stall = perf_stall_q;
    assign io.perf_flush = perf_flush_q;
`else
    assign io.perf_stall = '0;
    assign io.perf_flush = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (MUL_CYCLES=4, DIV_CYCLES=32).
// Perf counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipe_ctrl_if #(.CNT_W(6)) bus ();

    pipe_ctrl #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W(6)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_ps;
        logic [31:0] exp_pf;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.hz_stall    = 1'b1;
        bus.br_taken    = 1'b1;
        bus.ex_md_start = 1'b0;
        bus.ex_md_op    = 2'b00;
        bus.id_md_use   = 1'b0;

        // reset state, control outputs gated
        #3;
        chk("rst_pc_we", 32'(bus.pc_we), 32'd0);
        chk("rst_ifid_we", 32'(bus.ifid_we), 32'd0);
        chk("rst_idex_flush", 32'(bus.idex_flush), 32'd0);
        chk("rst_ifid_flush", 32'(bus.ifid_flush), 32'd0);
        chk("rst_busy", 32'(bus.md_busy), 32'd0);
        chk("rst_cnt", 32'(bus.md_cnt), 32'd0);
        chk("rst_done", 32'(bus.md_done), 32'd0);
        chk("rst_err", 32'(bus.md_err), 32'd0);
        chk("rst_perf_stall", bus.perf_stall, 32'd0);
        chk("rst_perf_flush", bus.perf_flush, 32'd0);
        bus.hz_stall = 1'b0;
        bus.br_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pc_we", 32'(bus.pc_we), 32'd1);
        step();

        // mult: 4 busy cycles counting 3..0, then DONE
        bus.ex_md_start = 1'b1;
        bus.ex_md_op    = 2'b00;
        step();
        bus.ex_md_start = 1'b0;
        chk("mul_busy0", 32'(bus.md_busy), 32'd1);
        chk("mul_cnt3", 32'(bus.md_cnt), 32'd3);
        step();
        chk("mul_cnt2", 32'(bus.md_cnt), 32'd2);
        step();
        chk("mul_cnt1", 32'(bus.md_cnt), 32'd1);
        step();
        chk("mul_cnt0", 32'(bus.md_cnt), 32'd0);
        chk("mul_done_early", 32'(bus.md_done), 32'd0);
        step();
        chk("mul_done", 32'(bus.md_done), 32'd1);
        chk("mul_busy_done", 32'(bus.md_busy), 32'd1);
        step();
        chk("mul_idle_busy", 32'(bus.md_busy), 32'd0);
        chk("mul_idle_done", 32'(bus.md_done), 32'd0);

        // start while busy is dropped with an md_err pulse
        bus.ex_md_start = 1'b1;
        bus.ex_md_op    = 2'b01;
        step();
        bus.ex_md_start = 1'b0;
        chk("err_cnt3", 32'(bus.md_cnt), 32'd3);
        step();
        chk("err_cnt2", 32'(bus.md_cnt), 32'd2);
        bus.ex_md_start = 1'b1;
        bus.ex_md_op    = 2'b10;
        #1;
        chk("err_before", 32'(bus.md_err), 32'd0);
        step();
        bus.ex_md_start = 1'b0;
        chk("err_pulse", 32'(bus.md_err), 32'd1);
        chk("err_cnt1", 32'(bus.md_cnt), 32'd1);
        step();
        chk("err_clear", 32'(bus.md_err), 32'd0);
        chk("err_cnt0", 32'(bus.md_cnt), 32'd0);
        step();
        chk("err_done", 32'(bus.md_done), 32'd1);
        step();
        chk("err_idle", 32'(bus.md_busy), 32'd0);

        // divide: MD users stall through DONE, others proceed
        bus.ex_md_start = 1'b1;
        bus.ex_md_op    = 2'b11;
        step();
        bus.ex_md_start = 1'b0;
        chk("div_cnt31", 32'(bus.md_cnt), 32'd31);
        #1;
        chk("div_nonmd_pc_we", 32'(bus.pc_we), 32'd1);
        chk("div_nonmd_idex", 32'(bus.idex_flush), 32'd0);
        bus.id_md_use = 1'b1;
        bus.br_taken  = 1'b1;
        #1;
        chk("div_md_ifid_flush", 32'(bus.ifid_flush), 32'd0);
        bus.br_taken = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            chk("div_pc_we", 32'(bus.pc_we), 32'd0);
            chk("div_ifid_we", 32'(bus.ifid_we), 32'd0);
            chk("div_idex_flush", 32'(bus.idex_flush), 32'd1);
            chk("div_cnt", 32'(bus.md_cnt), (k < 32) ? 32'(31 - k) : 32'd0);
            chk("div_done", 32'(bus.md_done), (k == 32) ? 32'd1 : 32'd0);
            step();
        end
        chk("div_idle_pc_we", 32'(bus.pc_we), 32'd1);
        chk("div_idle_idex", 32'(bus.idex_flush), 32'd0);
        bus.id_md_use = 1'b0;

        // hazard stall wins over a same-cycle branch
        bus.hz_stall = 1'b1;
        bus.br_taken = 1'b1;
        #1;
        chk("hz_br_ifid_flush", 32'(bus.ifid_flush), 32'd0);
        chk("hz_br_idex_flush", 32'(bus.idex_flush), 32'd1);
        chk("hz_br_pc_we", 32'(bus.pc_we), 32'd0);
        step();
        bus.hz_stall = 1'b0;
        #1;
        chk("br_ifid_flush", 32'(bus.ifid_flush), 32'd1);
        chk("br_pc_we", 32'(bus.pc_we), 32'd1);
        chk("br_idex_flush", 32'(bus.idex_flush), 32'd0);
        bus.br_taken = 1'b0;
        step();

        // async reset in the middle of a divide
        bus.ex_md_start = 1'b1;
        bus.ex_md_op    = 2'b10;
        step();
        bus.ex_md_start = 1'b0;
        for (int k = 0; k < 14; k++) step();
        chk("mid_div_cnt17", 32'(bus.md_cnt), 32'd17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.md_busy), 32'd0);
        chk("mid_rst_cnt", 32'(bus.md_cnt), 32'd0);
        chk("mid_rst_pc_we", 32'(bus.pc_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_pc_we", 32'(bus.pc_we), 32'd1);
        chk("mid_rel_busy", 32'(bus.md_busy), 32'd0);
        step();

        // 7 stall cycles then 3 flush cycles
        bus.hz_stall = 1'b1;
        for (int k = 0; k < 7; k++) step();
        bus.hz_stall = 1'b0;
        bus.br_taken = 1'b1;
        for (int k = 0; k < 3; k++) step();
        bus.br_taken = 1'b0;
        #1;
`ifdef PIPE_CTRL_PERF_EN
        exp_ps = 32'd7;
        exp_pf = 32'd3;
`else
        exp_ps = 32'd0;
        exp_pf = 32'd0;
`endif
        chk("perf_stall", bus.perf_stall, exp_ps);
        chk("perf_flush", bus.perf_flush, exp_pf);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
